fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controller that sequences the 16-bit Program Counter and Instruction Register instances through a two-byte instruction fetch from an 8-bit memory port.
- Drives the FunSel/E inputs of both registers and the memory read handshake.
- Handles jumps (PC parallel load), post-reset clearing and memory-timeout faults.
- Sits between the control unit (Start/Jump/Done) and the register/memory datapath.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a fetch state waits for MemAck before faulting (>=2)
LO_FIRST, 1, 1: first fetched byte goes to IR[7:0] (FunSel 101), second to IR[15:8] (FunSel 110); 0: reversed

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  request one instruction fetch; sampled in IDLE only
Jump  in  1  load PC from datapath (PC.I) this cycle; aborts any fetch
MemAck  in  1  memory byte valid on IR.I[7:0] this cycle
MemRead  out  1  memory read request (address = PC)
PC_FunSel  out  3  FunSel to PC register
PC_E  out  1  enable to PC register
IR_FunSel  out  3  FunSel to IR register
IR_E  out  1  enable to IR register
Busy  out  1  high in any state except IDLE and FAULT
Done  out  1  one-cycle pulse: both bytes loaded
Fault  out  1  high while in FAULT

Behaviour:
- States: CLR, IDLE, FETCH1, FETCH2, JUMP, DONE, FAULT. Registered state; outputs decoded combinationally from state plus MemAck (Mealy on the ack).
- Reset asserted (async): state=CLR, timeout count=0. While in reset all outputs are 0, including MemRead and enables.
- CLR (first cycle after reset release): PC_FunSel=IR_FunSel=011, PC_E=IR_E=1, Busy=1. Next state is IDLE. Jump is ignored in CLR.
- IDLE: Jump=1 goes to JUMP, and Start is ignored that cycle (not latched). Otherwise Start=1 goes to FETCH1.
- JUMP: PC_FunSel=010, PC_E=1, one cycle, then IDLE. Done is not pulsed.
- FETCH1/FETCH2: MemRead=1.
  - On MemAck=1 in the same cycle: IR_E=1 with IR_FunSel=101/110 per LO_FIRST and byte order, and PC_E=1 with PC_FunSel=001. Advance FETCH1 to FETCH2, or FETCH2 to DONE.
- DONE: Done=1, Busy=1, one cycle, then IDLE. Back-to-back Start is accepted only from IDLE.
- Timeout: counter cleared on entering each FETCH state and incremented each cycle without MemAck. If MemAck=0 with count == TIMEOUT_CYCLES-1, go to FAULT; no register enables that cycle.
- FAULT: Fault=1, MemRead=0, Busy=0. Stays until Jump (goes to JUMP, Fault drops) or Reset. Start is ignored.
  - A fault in FETCH2 leaves PC incremented once and IR half-loaded. This is by design; no rollback.
- Jump in FETCH1/FETCH2: abort and go to JUMP; no IR/PC increment that cycle, even if MemAck=1. Jump has priority over MemAck and timeout.
- Whenever an E output is 0, its FunSel is driven 3'b000.
- Minimum fetch with MemAck tied high:
  - Start sampled at edge 0.
  - FETCH1 in cycle 1, FETCH2 in cycle 2, DONE in cycle 3, IDLE in cycle 4.

Decomposition:
- Shared package: FunSel constants (FS_DEC=000, FS_INC=001, FS_LOAD=010, FS_CLR=011, FS_LO_ZX=100, FS_LO=101, FS_HI=110, FS_SEXT=111) and the state enum. Other register controllers reuse the same constants.
- One sub-module: fetch_timeout_counter. Inputs: clear, count-enable. Output: expired flag at TIMEOUT_CYCLES-1. Width is $clog2(TIMEOUT_CYCLES).

Test Plan:
- Reset release -> exactly one cycle with PC_E=IR_E=1, both FunSel=011, Busy=1; then IDLE with all outputs 0.
- Start with MemAck tied 1 (LO_FIRST=1) -> cycle 1: IR_FunSel=101 and PC_FunSel=001, both enables 1; cycle 2: IR_FunSel=110 and PC_FunSel=001; cycle 3: Done=1; cycle 4: Busy=0.
- Start, then MemAck delayed 3 cycles per byte -> MemRead held high, no enables until the ack cycle, Done at cycle 9, exactly two PC increments.
- TIMEOUT_CYCLES=4, MemAck never asserted -> FAULT after 4 FETCH1 cycles, Fault=1, MemRead=0, no enables. Start ignored. Jump -> PC_FunSel=010 for one cycle, then IDLE with Fault=0.
- Jump and MemAck both high in FETCH2 -> no IR enable and no PC increment that cycle; PC_FunSel=010 next cycle; no Done pulse.
- Reset asserted mid-FETCH1 with MemAck=1 -> MemRead and all enables drop to 0 immediately (asynchronous); after release, one CLR cycle, then IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared register-control constants and the fetch sequencer state encoding.
package fetch_sequencer_pkg;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_LO_ZX = 3'b100;
  localparam logic [2:0] FS_LO    = 3'b101;
  localparam logic [2:0] FS_HI    = 3'b110;
  localparam logic [2:0] FS_SEXT  = 3'b111;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_FETCH1,
    ST_FETCH2,
    ST_JUMP,
    ST_DONE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-acknowledged fetch cycles; flags the last allowed one.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (count_en)
      count <= count + W'(1);
  end

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences PC and IR through a two-byte fetch from an 8-bit memory port.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          LO_FIRST       = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Jump,
  input  logic       MemAck,
  output logic       MemRead,
  output logic [2:0] PC_FunSel,
  output logic       PC_E,
  output logic [2:0] IR_FunSel,
  output logic       IR_E,
  output logic       Busy,
  output logic       Done,
  output logic       Fault
);

  state_t state, next_state;
  logic   in_fetch, count_en, expired;

  assign in_fetch = (state == ST_FETCH1) || (state == ST_FETCH2);
  // Counter runs only on idle fetch cycles, so any ack or state change restarts it.
  assign count_en = in_fetch && !MemAck && !Jump;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (Clock),
    .reset   (Reset),
    .clear   (!count_en),
    .count_en(count_en),
    .expired (expired)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state <= ST_CLR;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    MemRead    = 1'b0;
    PC_FunSel  = FS_DEC;
    PC_E       = 1'b0;
    IR_FunSel  = FS_DEC;
    IR_E       = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    Fault      = 1'b0;
    case (state)
      ST_CLR: begin
        PC_FunSel  = FS_CLR;
        PC_E       = 1'b1;
        IR_FunSel  = FS_CLR;
        IR_E       = 1'b1;
        Busy       = 1'b1;
        next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (Jump)
          next_state = ST_JUMP;
        else if (Start)
          next_state = ST_FETCH1;
      end
      ST_FETCH1, ST_FETCH2: begin
        MemRead = 1'b1;
        Busy    = 1'b1;
        if (Jump) begin
          next_state = ST_JUMP;
        end else if (MemAck) begin
          IR_E       = 1'b1;
          IR_FunSel  = ((state == ST_FETCH1) == LO_FIRST) ? FS_LO : FS_HI;
          PC_E       = 1'b1;
          PC_FunSel  = FS_INC;
          next_state = (state == ST_FETCH1) ? ST_FETCH2 : ST_DONE;
        end else if (expired) begin
          next_state = ST_FAULT;
        end
      end
      ST_JUMP: begin
        PC_FunSel  = FS_LOAD;
        PC_E       = 1'b1;
        Busy       = 1'b1;
        next_state = ST_IDLE;
      end
      ST_DONE: begin
        Done       = 1'b1;
        Busy       = 1'b1;
        next_state = ST_IDLE;
      end
      ST_FAULT: begin
        Fault = 1'b1;
        if (Jump)
          next_state = ST_JUMP;
      end
      default: next_state = ST_CLR;
    endcase
    // State sits in CLR during reset, so its decode must be masked here.
    if (Reset) begin
      MemRead   = 1'b0;
      PC_FunSel = FS_DEC;
      PC_E      = 1'b0;
      IR_FunSel = FS_DEC;
      IR_E      = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      Fault     = 1'b0;
    end
  end

endmodule
